// File: rtl/unidade_mult_div_if.sv
// Request/response bundle between the control unit and the Hi/Lo mult/div unit.
// The control unit is the master and the arithmetic unit is the slave.
interface unidade_mult_div_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       ALUop;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [WIDTH-1:0] Resultado;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             busy;
    logic             done;
    logic             stall;
    logic             div_zero;

    modport master (
        output start, ALUop, op1, op2,
        input  Resultado, Hi, Lo, busy, done, stall, div_zero
    );

    modport slave (
        input  start, ALUop, op1, op2,
        output Resultado, Hi, Lo, busy, done, stall, div_zero
    );
endinterface

// File: rtl/unidade_mult_div.sv
// Iterative unsigned multiply/divide unit owning the Hi/Lo register pair.
// mult uses shift-add, div uses restoring division; both take WIDTH cycles.
// mfhi/mflo copy Hi or Lo into Resultado in a single cycle.
module unidade_mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    unidade_mult_div_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] OP_MULT = 5'b00100;
    localparam logic [4:0] OP_DIV  = 5'b00101;
    localparam logic [4:0] OP_MFHI = 5'b01101;
    localparam logic [4:0] OP_MFLO = 5'b01110;

    localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    // Shared 2*WIDTH accumulator: {partial product, multiplier} for mult,
    // {remainder, quotient} for div.
    logic [1:0]         r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_res;
    logic [CW-1:0]      r_cnt;
    logic               r_div_zero;

    logic               w_busy;
    logic               w_last;
    logic [WIDTH:0]     w_mult_sum;
    logic [2*WIDTH-1:0] w_mult_next;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_rem_ge;
    logic [WIDTH-1:0]   w_rem_sub;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_busy = (r_state == S_MULT) || (r_state == S_DIV);
    assign w_last = (r_cnt == LAST_ITER);

    // Shift-add step: conditional add into the upper half keeps its carry,
    // which becomes the new MSB after the right shift.
    assign w_mult_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                       + {1'b0, (r_acc[0] ? r_op1 : {WIDTH{1'b0}})};
    assign w_mult_next = {w_mult_sum, r_acc[WIDTH-1:1]};

    // Restoring step: the shifted remainder needs one extra bit for the
    // compare; after a successful subtract the result always fits in WIDTH.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_rem_ge   = (w_rem_sh >= {1'b0, r_op2});
    assign w_rem_sub  = w_rem_sh[WIDTH-1:0] - r_op2;
    assign w_div_next = {(w_rem_ge ? w_rem_sub : w_rem_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_rem_ge};

    // Control FSM, datapath iteration and Hi/Lo/Resultado updates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_acc      <= '0;
            r_op1      <= '0;
            r_op2      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            case (r_state)
                S_MULT: begin
                    r_acc <= w_mult_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_hi    <= w_mult_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_mult_next[WIDTH-1:0];
                        r_state <= S_DONE;
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_hi    <= w_div_next[2*WIDTH-1:WIDTH];
                        r_lo    <= w_div_next[WIDTH-1:0];
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE both accept requests; DONE lasts one cycle
                    r_state <= S_IDLE;
                    if (bus.start) begin
                        case (bus.ALUop)
                            OP_MULT: begin
                                r_op1      <= bus.op1;
                                r_op2      <= bus.op2;
                                r_acc      <= {{WIDTH{1'b0}}, bus.op2};
                                r_cnt      <= '0;
                                r_div_zero <= 1'b0;
                                r_state    <= S_MULT;
                            end
                            OP_DIV: begin
                                if (bus.op2 == '0) begin
                                    // No iteration: results are fixed values
                                    r_hi       <= bus.op1;
                                    r_lo       <= '1;
                                    r_div_zero <= 1'b1;
                                    r_state    <= S_DONE;
                                end else begin
                                    r_op1      <= bus.op1;
                                    r_op2      <= bus.op2;
                                    r_acc      <= {{WIDTH{1'b0}}, bus.op1};
                                    r_cnt      <= '0;
                                    r_div_zero <= 1'b0;
                                    r_state    <= S_DIV;
                                end
                            end
                            OP_MFHI: begin
                                r_res   <= r_hi;
                                r_state <= S_DONE;
                            end
                            OP_MFLO: begin
                                r_res   <= r_lo;
                                r_state <= S_DONE;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.Resultado = r_res;
    assign bus.Hi        = r_hi;
    assign bus.Lo        = r_lo;
    assign bus.busy      = w_busy;
    assign bus.stall     = w_busy;
    assign bus.done      = (r_state == S_DONE);
    assign bus.div_zero  = r_div_zero;
endmodule

// File: tb/tb_unidade_mult_div.sv
// Scoreboard bench for unidade_mult_div: the driver pushes expected results
// computed with plain arithmetic; a forked monitor pops one entry per done.
module tb_unidade_mult_div;
    localparam logic [4:0] OP_MULT = 5'b00100;
    localparam logic [4:0] OP_DIV  = 5'b00101;
    localparam logic [4:0] OP_MFHI = 5'b01101;
    localparam logic [4:0] OP_MFLO = 5'b01110;
    localparam logic [4:0] OP_ADD  = 5'b00010;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] res;
        logic        dz;
    } sb_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_stop = 1'b0;

    // Reference model state
    logic [31:0] m_hi = '0, m_lo = '0, m_res = '0;
    logic        m_dz = 1'b0;
    logic [31:0] hold_hi = '0, hold_lo = '0;
    int          busy_end = 0;
    sb_t         sb[$];

    unidade_mult_div_if #(.WIDTH(32)) bus ();

    unidade_mult_div #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Edge counter: a negedge sample after edge E_k sees cyc == k
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        sb_t e;
        logic exp_busy;
        while (!mon_stop) begin
            @(negedge clock);
            if (reset) begin
                exp_busy = (cyc < busy_end);
                check("busy", 32'(bus.busy), 32'(exp_busy));
                check("stall", 32'(bus.stall), 32'(exp_busy));
                if (exp_busy) begin
                    check("hi_stable", bus.Hi, hold_hi);
                    check("lo_stable", bus.Lo, hold_lo);
                end
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        $display("txn cycle=%0d Hi=%h Lo=%h Resultado=%h div_zero=%0d",
                                 cyc, bus.Hi, bus.Lo, bus.Resultado, bus.div_zero);
                        check("done_cycle", 32'(cyc), 32'(e.cyc));
                        check("Hi", bus.Hi, e.hi);
                        check("Lo", bus.Lo, e.lo);
                        check("Resultado", bus.Resultado, e.res);
                        check("div_zero", 32'(bus.div_zero), 32'(e.dz));
                    end
                end
            end
        end
    endtask

    // Called at a negedge; holds start until the model says the unit is free,
    // returns at the negedge following the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int acc_cyc);
        bit          acc;
        sb_t         e;
        logic [63:0] prod;
        acc = 1'b0;
        bus.start = 1'b1;
        bus.ALUop = op;
        bus.op1   = a;
        bus.op2   = b;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = (cyc >= busy_end);
            @(posedge clock);
            if (!acc) @(negedge clock);
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no accept expected accept within 100 cycles");
        end
        #1;
        acc_cyc   = cyc;
        bus.start = 1'b0;
        bus.op1   = $urandom;
        bus.op2   = $urandom;
        e.cyc = acc_cyc;
        case (op)
            OP_MULT: begin
                hold_hi  = m_hi;
                hold_lo  = m_lo;
                prod     = 64'(a) * 64'(b);
                m_hi     = prod[63:32];
                m_lo     = prod[31:0];
                m_dz     = 1'b0;
                busy_end = acc_cyc + 32;
                e.cyc    = acc_cyc + 32;
            end
            OP_DIV: begin
                if (b == 0) begin
                    m_hi = a;
                    m_lo = 32'hFFFF_FFFF;
                    m_dz = 1'b1;
                end else begin
                    hold_hi  = m_hi;
                    hold_lo  = m_lo;
                    m_hi     = a % b;
                    m_lo     = a / b;
                    m_dz     = 1'b0;
                    busy_end = acc_cyc + 32;
                    e.cyc    = acc_cyc + 32;
                end
            end
            OP_MFHI: m_res = m_hi;
            default: m_res = m_lo;
        endcase
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.res = m_res;
        e.dz  = m_dz;
        sb.push_back(e);
        @(negedge clock);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 100 && (sb.size() > 0 || cyc < busy_end); n++) @(negedge clock);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending ops expected 0", sb.size());
        end
        @(negedge clock);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 20));
            2:       return 32'hFFFF_FFFF;
            default: return 32'h8000_0000 | 32'($urandom_range(0, 3));
        endcase
    endfunction

    initial begin
        int          c;
        logic [31:0] a, b;
        bus.start = 1'b0;
        bus.ALUop = '0;
        bus.op1   = '0;
        bus.op2   = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_Hi", bus.Hi, 32'd0);
        check("rst_Lo", bus.Lo, 32'd0);
        check("rst_Resultado", bus.Resultado, 32'd0);
        check("rst_div_zero", 32'(bus.div_zero), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Directed: full-scale mult, divides, divide by zero
        issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, c);
        issue(OP_DIV, 32'd100, 32'd7, c);
        issue(OP_DIV, 32'h8000_0000, 32'd3, c);
        wait_idle();
        issue(OP_DIV, 32'd5, 32'd0, c);
        check("dz_no_busy", 32'(bus.busy), 32'd0);
        issue(OP_MULT, 32'd3, 32'd4, c);
        wait_idle();

        // mflo held through stall, then mfhi
        issue(OP_MULT, 32'd6, 32'd7, c);
        issue(OP_MFLO, 32'd0, 32'd0, c);
        issue(OP_MFHI, 32'd0, 32'd0, c);
        wait_idle();

        // Reset in the middle of a mult
        issue(OP_MULT, 32'h1234_5678, 32'h10, c);
        while (cyc < c + 10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_Hi", bus.Hi, 32'd0);
        check("abort_Lo", bus.Lo, 32'd0);
        sb.delete();
        busy_end = 0;
        m_hi = '0; m_lo = '0; m_res = '0; m_dz = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        issue(OP_MFHI, 32'd0, 32'd0, c);
        wait_idle();

        // Unrecognised ALUop is ignored
        bus.start = 1'b1;
        bus.ALUop = OP_ADD;
        bus.op1   = $urandom;
        bus.op2   = $urandom;
        repeat (4) @(negedge clock);
        bus.start = 1'b0;
        check("ign_Hi", bus.Hi, m_hi);
        check("ign_Lo", bus.Lo, m_lo);
        check("ign_Resultado", bus.Resultado, m_res);

        // Randomized mix, sometimes back-to-back, sometimes from IDLE
        for (int i = 0; i < 24; i++) begin
            a = rnd_operand();
            b = rnd_operand();
            case ($urandom_range(0, 5))
                0, 1:    issue(OP_MULT, a, b, c);
                2:       issue(OP_DIV, a, b, c);
                3:       issue(OP_DIV, a, ($urandom_range(0, 1) != 0) ? 32'd0 : b, c);
                4:       issue(OP_MFHI, a, b, c);
                default: issue(OP_MFLO, a, b, c);
            endcase
            if ($urandom_range(0, 1) != 0) wait_idle();
        end
        wait_idle();

        mon_stop = 1'b1;
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/unidade_mult_div.md
Name: unidade_mult_div

Overview:
Multi-cycle controller that owns the Hi/Lo register pair and sequences unsigned mult/div as iterative 32-step operations. It replaces single-cycle `*`, `/` and `%` in the ALU path.
- Accepts mult, div, mfhi and mflo requests from the control unit.
- Raises `stall` while an operation is in flight.
- Returns mfhi/mflo data on `Resultado`.
The ALU keeps all other ALUop codes.

Parameters:
WIDTH, 32, operand width; Hi/Lo are WIDTH each; iteration count = WIDTH.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request valid, sampled at rising edge
ALUop  input  5  operation code: 00100 mult, 00101 div, 01101 mfhi, 01110 mflo; all others ignored
op1  input  WIDTH  multiplicand / dividend
op2  input  WIDTH  multiplier / divisor
Resultado  output  WIDTH  mfhi/mflo result register
Hi  output  WIDTH  high product / remainder
Lo  output  WIDTH  low product / quotient
busy  output  1  state is MULT or DIV
done  output  1  one-cycle completion pulse
stall  output  1  pipeline hold; equals busy, combinational from the state register
div_zero  output  1  last div had op2 == 0; sticky

Behaviour:
- Reset (reset == 0, async): state = IDLE; Hi, Lo, Resultado, internal accumulator and counter = 0; busy = done = div_zero = 0. Reset mid-operation aborts it with no partial Hi/Lo update.
- States: IDLE, MULT, DIV, DONE. A request is accepted only in IDLE or DONE. In MULT/DIV, start is ignored; the requester must hold start while stall is high.
- Accept of mult (ALUop 00100):
  - Latch op1/op2, counter = 0, 2·WIDTH accumulator = {0, op2}, state = MULT, div_zero = 0.
- MULT, per cycle:
  - If acc[0] == 1, add op1 to acc[2W-1:W] with carry-out kept.
  - Shift acc right 1, carry into MSB; counter++.
  - On the edge processing iteration WIDTH-1: Hi = acc[2W-1:W], Lo = acc[W-1:0], state = DONE.
- Accept of div (ALUop 00101), op2 != 0:
  - Latch operands, remainder = 0, quotient = op1, counter = 0, state = DIV, div_zero = 0.
- DIV, per cycle (restoring):
  - rem = {rem, q[MSB]}; q <<= 1.
  - If rem >= divisor: rem -= divisor, q[0] = 1.
  - Final edge: Hi = remainder, Lo = quotient, state = DONE.
- Accept of div with op2 == 0:
  - No iteration; on the accepting edge Hi = op1, Lo = all-ones, div_zero = 1, state = DONE.
- Latency: start sampled at edge E0 → busy high E0..E_WIDTH → Hi/Lo written at edge E_WIDTH (E32) → done high for the cycle after E32 → IDLE at E33 unless a new request is accepted then. Div-by-zero: done high for the cycle after E0.
- mfhi (01101) / mflo (01110) accepted in IDLE/DONE:
  - Resultado = Hi / Lo at the accepting edge; state = DONE (done pulses next cycle); Hi/Lo unchanged.
  - Resultado holds its value otherwise.
- DONE → IDLE after one cycle. If start is valid in DONE, the new request is accepted directly (back-to-back, no bubble).
- start with any other ALUop: ignored, no state change, no done.
- Arithmetic is unsigned only. Hi/Lo are never partially updated; they stay stable throughout MULT/DIV.
- Operand inputs may change after the accepting edge without effect.

Test Plan:
1. Reset, then mult op1 = 0xFFFFFFFF, op2 = 0xFFFFFFFF → busy 32 cycles, done one cycle after E32, Hi = 0xFFFFFFFE, Lo = 0x00000001.
2. div op1 = 100, op2 = 7 → Lo = 14, Hi = 2, div_zero = 0. Then div op1 = 0x80000000, op2 = 3 → Lo = 0x2AAAAAAA, Hi = 2.
3. div op1 = 5, op2 = 0 → done the cycle after accept, busy never high, Hi = 5, Lo = 0xFFFFFFFF, div_zero = 1. Then mult 3·4 → div_zero = 0, Lo = 12, Hi = 0.
4. mult 6·7; hold start with ALUop = 01110 from cycle 2:
   - Ignored while stall = 1.
   - Accepted in the DONE cycle; next done pulse with Resultado = 42.
   - mfhi then gives Resultado = 0.
5. Start mult 0x12345678·0x10; assert reset low at iteration 10 → immediately busy = 0, Hi = Lo = 0, state IDLE. Release reset; mfhi → Resultado = 0.
6. start with ALUop = 00010 (add) in IDLE → no busy, no done, Hi/Lo/Resultado unchanged.
